// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Pipeline hazard unit for a 5-stage in-order core with a multi-cycle
//   (mul/div) side path. It does three jobs:
//     - selects the Execute operand forwarding sources (Memory beats Writeback)
//     - keeps a per-register pending scoreboard for in-flight multi-cycle results
//     - produces per-stage stall and Execute flush signals (load-use, RAW, WAW,
//       ALU busy and memory not ready)
//   Register 0 is hardwired and never forwards, stalls or becomes pending.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   When defined, saturating counters of d_stall cycles and load-use cycles are
//   built. When undefined, stall_cycles and load_use_cnt are constant 0.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   d_*                   Decode instruction (valid, sources, dest, write, multi-cycle)
//   x_*                   Execute instruction indices and status
//   m_*, w_*              Memory / Writeback destinations and write flags
//   f/d/x/m_stall         per-stage stall, x_flush inserts an Execute bubble
//   x_fwd_sel_1/2         00 regfile, 01 Memory stage, 10 Writeback stage
//   stall_cycles          saturating count of d_stall cycles
//   load_use_cnt          saturating count of load-use hazard cycles
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_src_reg_1,
    input  logic [REG_ADDR_W-1:0] d_src_reg_2,
    input  logic [REG_ADDR_W-1:0] d_dst_reg,
    input  logic                  d_reg_write,
    input  logic                  d_multi,
    input  logic [REG_ADDR_W-1:0] x_src_reg_1,
    input  logic [REG_ADDR_W-1:0] x_src_reg_2,
    input  logic [REG_ADDR_W-1:0] x_dst_reg,
    input  logic                  x_valid,
    input  logic                  x_reg_write,
    input  logic                  x_mem_read,
    input  logic                  x_alu_ready,
    input  logic [REG_ADDR_W-1:0] m_dst_reg,
    input  logic [REG_ADDR_W-1:0] w_dst_reg,
    input  logic                  m_reg_write,
    input  logic                  w_reg_write,
    input  logic                  w_multi,
    input  logic                  m_mem_ready,
    output logic                  f_stall,
    output logic                  d_stall,
    output logic                  x_stall,
    output logic                  m_stall,
    output logic                  x_flush,
    output logic [1:0]            x_fwd_sel_1,
    output logic [1:0]            x_fwd_sel_2,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      load_use_cnt
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                load_use;
    logic                raw_hazard;
    logic                waw_hazard;

    // Forwarding: the younger producer (Memory) wins over Writeback.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  m_wr,
        input logic [REG_ADDR_W-1:0] m_dst,
        input logic                  w_wr,
        input logic [REG_ADDR_W-1:0] w_dst
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (m_wr && (m_dst == src))
                sel = 2'b01;
            else if (w_wr && (w_dst == src))
                sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        x_fwd_sel_1 = fwd_sel(x_src_reg_1, m_reg_write, m_dst_reg, w_reg_write, w_dst_reg);
        x_fwd_sel_2 = fwd_sel(x_src_reg_2, m_reg_write, m_dst_reg, w_reg_write, w_dst_reg);
    end

    // Stall network. pending_q[0] is held at 0, so RAW/WAW on r0 cannot fire.
    always_comb begin
        load_use   = d_valid & x_valid & x_mem_read & x_reg_write & (x_dst_reg != '0) &
                     ((x_dst_reg == d_src_reg_1) | (x_dst_reg == d_src_reg_2));
        raw_hazard = d_valid & (pending_q[d_src_reg_1] | pending_q[d_src_reg_2]);
        waw_hazard = d_valid & d_reg_write & pending_q[d_dst_reg];
        m_stall    = ~m_mem_ready;
        x_stall    = m_stall | (x_valid & x_reg_write & ~x_alu_ready);
        d_stall    = x_stall | load_use | raw_hazard | waw_hazard;
        f_stall    = d_stall;
        // Bubble only when Execute is free to take it.
        x_flush    = d_stall & ~x_stall;
    end

    // Scoreboard next state: clear first so a same-edge set on the same
    // register wins.
    always_comb begin
        pending_d = pending_q;
        if (w_reg_write && w_multi)
            pending_d[w_dst_reg] = 1'b0;
        if (d_valid && !d_stall && d_reg_write && d_multi)
            pending_d[d_dst_reg] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset)
            pending_q <= '0;
        else
            pending_q <= pending_d;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;

    // Saturating: stop at all-ones instead of wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        load_use_cnt_d = load_use_cnt_q;
        if (d_stall && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (load_use && (load_use_cnt_q != '1))
            load_use_cnt_d = load_use_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            load_use_cnt_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            load_use_cnt_q <= load_use_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign load_use_cnt = load_use_cnt_q;
`else
    assign stall_cycles = '0;
    assign load_use_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit. Counters are built 4 bits wide
// so saturation is reachable in a few cycles.
module tb_hazard_scoreboard_unit;

    localparam int AW = 5;
    localparam int CW = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          d_valid, d_reg_write, d_multi;
    logic [AW-1:0] d_src_reg_1, d_src_reg_2, d_dst_reg;
    logic [AW-1:0] x_src_reg_1, x_src_reg_2, x_dst_reg;
    logic          x_valid, x_reg_write, x_mem_read, x_alu_ready;
    logic [AW-1:0] m_dst_reg, w_dst_reg;
    logic          m_reg_write, w_reg_write, w_multi, m_mem_ready;
    logic          f_stall, d_stall, x_stall, m_stall, x_flush;
    logic [1:0]    x_fwd_sel_1, x_fwd_sel_2;
    logic [CW-1:0] stall_cycles, load_use_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // {f_stall, d_stall, x_stall, m_stall, x_flush}
    wire [4:0] stat = {f_stall, d_stall, x_stall, m_stall, x_flush};
    wire [3:0] fwd  = {x_fwd_sel_1, x_fwd_sel_2};

    hazard_scoreboard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .d_valid(d_valid), .d_src_reg_1(d_src_reg_1), .d_src_reg_2(d_src_reg_2),
        .d_dst_reg(d_dst_reg), .d_reg_write(d_reg_write), .d_multi(d_multi),
        .x_src_reg_1(x_src_reg_1), .x_src_reg_2(x_src_reg_2), .x_dst_reg(x_dst_reg),
        .x_valid(x_valid), .x_reg_write(x_reg_write), .x_mem_read(x_mem_read),
        .x_alu_ready(x_alu_ready), .m_dst_reg(m_dst_reg), .w_dst_reg(w_dst_reg),
        .m_reg_write(m_reg_write), .w_reg_write(w_reg_write), .w_multi(w_multi),
        .m_mem_ready(m_mem_ready), .f_stall(f_stall), .d_stall(d_stall),
        .x_stall(x_stall), .m_stall(m_stall), .x_flush(x_flush),
        .x_fwd_sel_1(x_fwd_sel_1), .x_fwd_sel_2(x_fwd_sel_2),
        .stall_cycles(stall_cycles), .load_use_cnt(load_use_cnt)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        d_valid = 0; d_reg_write = 0; d_multi = 0;
        d_src_reg_1 = 0; d_src_reg_2 = 0; d_dst_reg = 0;
        x_src_reg_1 = 0; x_src_reg_2 = 0; x_dst_reg = 0;
        x_valid = 0; x_reg_write = 0; x_mem_read = 0; x_alu_ready = 1;
        m_dst_reg = 0; w_dst_reg = 0;
        m_reg_write = 0; w_reg_write = 0; w_multi = 0; m_mem_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step(); step();
        reset = 0;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL reset_stat got %b want %b", stat, 5'b00000); end
        n_cmp++;
        if (fwd !== 4'b0000) begin n_err++; $display("FAIL reset_fwd got %b want %b", fwd, 4'b0000); end
        n_cmp++;
        if (stall_cycles !== 4'd0 || load_use_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cycles, load_use_cnt);
        end
    endtask

    task automatic test_load_use();
        idle();
        // x: lw r5 ; d: add r6, r5, r1
        x_valid = 1; x_reg_write = 1; x_mem_read = 1; x_dst_reg = 5;
        d_valid = 1; d_reg_write = 1; d_dst_reg = 6; d_src_reg_1 = 5; d_src_reg_2 = 1;
        #1;
        n_cmp++;
        if (stat !== 5'b11001) begin n_err++; $display("FAIL load_use_stat got %b want %b", stat, 5'b11001); end
        step();
        // load now in Memory, add in Execute
        idle();
        m_reg_write = 1; m_dst_reg = 5;
        x_valid = 1; x_reg_write = 1; x_dst_reg = 6; x_src_reg_1 = 5; x_src_reg_2 = 1;
        #1;
        n_cmp++;
        if (fwd !== 4'b0100) begin n_err++; $display("FAIL load_use_fwd got %b want %b", fwd, 4'b0100); end
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL load_use_release got %b want %b", stat, 5'b00000); end
        n_cmp++;
        if (stall_cycles !== (PERF ? 4'd1 : 4'd0) || load_use_cnt !== (PERF ? 4'd1 : 4'd0)) begin
            n_err++; $display("FAIL load_use_cnt got %0d/%0d want %0d/%0d", stall_cycles, load_use_cnt,
                              PERF ? 1 : 0, PERF ? 1 : 0);
        end
        // r0 load never hazards
        idle();
        x_valid = 1; x_reg_write = 1; x_mem_read = 1; x_dst_reg = 0;
        d_valid = 1; d_src_reg_1 = 0; d_src_reg_2 = 0;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL load_use_r0 got %b want %b", stat, 5'b00000); end
        // non-load producer is forwarded, no stall
        x_mem_read = 0; x_dst_reg = 5; d_src_reg_2 = 5;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL load_use_alu got %b want %b", stat, 5'b00000); end
        idle();
        step();
    endtask

    task automatic test_multi_cycle();
        idle();
        // d: mul r7, r1, r2
        d_valid = 1; d_reg_write = 1; d_multi = 1; d_dst_reg = 7; d_src_reg_1 = 1; d_src_reg_2 = 2;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL mul_issue got %b want %b", stat, 5'b00000); end
        step();
        // WAW probe on r7
        d_multi = 0;
        #1;
        n_cmp++;
        if (stat !== 5'b11001) begin n_err++; $display("FAIL waw_stall got %b want %b", stat, 5'b11001); end
        step();
        // d: add r8, r7, r2 held while r7 pending
        d_dst_reg = 8; d_src_reg_1 = 7; d_src_reg_2 = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (stat !== 5'b11001) begin n_err++; $display("FAIL raw_stall[%0d] got %b want %b", i, stat, 5'b11001); end
            step();
        end
        // writeback of r7 this cycle: still stalled, released next cycle
        w_reg_write = 1; w_multi = 1; w_dst_reg = 7;
        #1;
        n_cmp++;
        if (stat !== 5'b11001) begin n_err++; $display("FAIL raw_wb_cycle got %b want %b", stat, 5'b11001); end
        step();
        w_reg_write = 0; w_multi = 0; w_dst_reg = 0;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL raw_release got %b want %b", stat, 5'b00000); end
        n_cmp++;
        if (stall_cycles !== (PERF ? 4'd6 : 4'd0) || load_use_cnt !== (PERF ? 4'd1 : 4'd0)) begin
            n_err++; $display("FAIL multi_cnt got %0d/%0d want %0d/%0d", stall_cycles, load_use_cnt,
                              PERF ? 6 : 0, PERF ? 1 : 0);
        end
        step();
        // mul r0 must not create a scoreboard entry
        idle();
        d_valid = 1; d_reg_write = 1; d_multi = 1; d_dst_reg = 0;
        step();
        d_multi = 0; d_reg_write = 0; d_src_reg_1 = 0;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL mul_r0 got %b want %b", stat, 5'b00000); end
        idle();
        step();
    endtask

    task automatic test_forward();
        idle();
        m_reg_write = 1; m_dst_reg = 3; w_reg_write = 1; w_dst_reg = 3;
        x_src_reg_1 = 1; x_src_reg_2 = 3;
        #1;
        n_cmp++;
        if (fwd !== 4'b0001) begin n_err++; $display("FAIL fwd_mem_wins got %b want %b", fwd, 4'b0001); end
        m_reg_write = 0;
        #1;
        n_cmp++;
        if (fwd !== 4'b0010) begin n_err++; $display("FAIL fwd_wb got %b want %b", fwd, 4'b0010); end
        m_reg_write = 1; m_dst_reg = 0; w_dst_reg = 0; x_src_reg_1 = 0; x_src_reg_2 = 0;
        #1;
        n_cmp++;
        if (fwd !== 4'b0000) begin n_err++; $display("FAIL fwd_r0 got %b want %b", fwd, 4'b0000); end
        m_dst_reg = 2; w_dst_reg = 3; x_src_reg_1 = 2; x_src_reg_2 = 3;
        #1;
        n_cmp++;
        if (fwd !== 4'b0110) begin n_err++; $display("FAIL fwd_split got %b want %b", fwd, 4'b0110); end
        idle();
        step();
    endtask

    task automatic test_exec_stall();
        idle();
        x_valid = 0; x_reg_write = 1; x_alu_ready = 0;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL alu_not_valid got %b want %b", stat, 5'b00000); end
        x_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (stat !== 5'b11100) begin n_err++; $display("FAIL alu_stall[%0d] got %b want %b", i, stat, 5'b11100); end
            step();
        end
        x_alu_ready = 1; m_mem_ready = 0;
        #1;
        n_cmp++;
        if (stat !== 5'b11110) begin n_err++; $display("FAIL mem_stall got %b want %b", stat, 5'b11110); end
        step();
        idle();
        #1;
        n_cmp++;
        if (stall_cycles !== (PERF ? 4'd11 : 4'd0)) begin
            n_err++; $display("FAIL exec_cnt got %0d want %0d", stall_cycles, PERF ? 11 : 0);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        // issue mul r9 and retire r9 on the same edge: set wins
        d_valid = 1; d_reg_write = 1; d_multi = 1; d_dst_reg = 9;
        w_reg_write = 1; w_multi = 1; w_dst_reg = 9;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL b2b_issue got %b want %b", stat, 5'b00000); end
        step();
        idle();
        d_valid = 1; d_src_reg_1 = 9;
        #1;
        n_cmp++;
        if (stat !== 5'b11001) begin n_err++; $display("FAIL b2b_set_wins got %b want %b", stat, 5'b11001); end
        step();
        idle();
    endtask

    task automatic test_saturate();
        idle();
        x_valid = 1; x_reg_write = 1; x_alu_ready = 0;
        for (int i = 0; i < 6; i++) step();
        idle();
        #1;
        n_cmp++;
        if (stall_cycles !== (PERF ? 4'd15 : 4'd0)) begin
            n_err++; $display("FAIL sat_cnt got %0d want %0d", stall_cycles, PERF ? 15 : 0);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        // r9 still pending; stalled cycle must not wrap the saturated counter
        d_valid = 1; d_src_reg_1 = 9;
        #1;
        n_cmp++;
        if (stat !== 5'b11001) begin n_err++; $display("FAIL pend9_before_reset got %b want %b", stat, 5'b11001); end
        step();
        n_cmp++;
        if (stall_cycles !== (PERF ? 4'd15 : 4'd0)) begin
            n_err++; $display("FAIL sat_hold got %0d want %0d", stall_cycles, PERF ? 15 : 0);
        end
        // reset while a mul r10 is presented: no set that cycle
        idle();
        reset = 1;
        d_valid = 1; d_reg_write = 1; d_multi = 1; d_dst_reg = 10;
        step();
        reset = 0;
        idle();
        #1;
        n_cmp++;
        if (stall_cycles !== 4'd0 || load_use_cnt !== 4'd0) begin
            n_err++; $display("FAIL reset_mid_cnt got %0d/%0d want 0/0", stall_cycles, load_use_cnt);
        end
        d_valid = 1; d_src_reg_1 = 9; d_src_reg_2 = 10;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL reset_mid_pend got %b want %b", stat, 5'b00000); end
        // stale writeback to a non-pending register is harmless
        d_valid = 0;
        w_reg_write = 1; w_multi = 1; w_dst_reg = 9;
        step();
        idle();
        d_valid = 1; d_src_reg_1 = 9;
        #1;
        n_cmp++;
        if (stat !== 5'b00000) begin n_err++; $display("FAIL stale_wb got %b want %b", stat, 5'b00000); end
        idle();
        step();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_load_use();
        test_multi_cycle();
        test_forward();
        test_exec_stall();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register index width; register count = 2**REG_ADDR_W.
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d_valid  input  1  Decode holds a valid instruction.
REQ-006 d_src_reg_1, d_src_reg_2  input  REG_ADDR_W  Decode source indices.
REQ-007 d_dst_reg  input  REG_ADDR_W  Decode destination index.
REQ-008 d_reg_write, d_multi  input  1  Decode writes a register; the op is multi-cycle (mul/div).
REQ-009 x_src_reg_1, x_src_reg_2, x_dst_reg  input  REG_ADDR_W  Execute indices.
REQ-010 x_valid, x_reg_write, x_mem_read, x_alu_ready  input  1  Execute status; x_mem_read marks a load.
REQ-011 m_dst_reg, w_dst_reg  input  REG_ADDR_W  Memory/Writeback destination indices.
REQ-012 m_reg_write, w_reg_write, w_multi, m_mem_ready  input  1  Stage write flags; Writeback retires a multi-cycle result; memory ready.
REQ-013 f_stall, d_stall, x_stall, m_stall  output  1  per-stage stall.
REQ-014 x_flush  output  1  insert bubble into Execute next cycle.
REQ-015 x_fwd_sel_1, x_fwd_sel_2  output  2  operand source: 00 regfile, 01 Memory stage, 10 Writeback stage.
REQ-016 stall_cycles, load_use_cnt  output  CNT_W  performance counters.

Function
REQ-017 Register index 0 SHALL never cause a hazard, forward, or scoreboard entry.
REQ-018 Forwarding (combinational): x_fwd_sel_n = 01 if m_reg_write and m_dst_reg == x_src_reg_n; else 10 if w_reg_write and w_dst_reg == x_src_reg_n; else 00; Memory beats Writeback.
REQ-019 Load-use hazard: d_valid & x_valid & x_mem_read & x_reg_write & (x_dst_reg equals either d_src, nonzero) SHALL assert d_stall.
REQ-020 Scoreboard: one pending bit per register, registered.
REQ-021 Pending[r] SHALL set on the edge where d_valid & ~d_stall & d_reg_write & d_multi & d_dst_reg == r.
REQ-022 Pending[r] SHALL clear on the edge where w_reg_write & w_multi & w_dst_reg == r.
REQ-023 Simultaneous set and clear of the same register: set wins.
REQ-024 RAW stall: d_valid with either d_src pending SHALL assert d_stall; WAW stall: d_valid & d_reg_write with d_dst_reg pending SHALL assert d_stall.
REQ-025 m_stall = ~m_mem_ready.
REQ-026 x_stall = m_stall | (x_valid & x_reg_write & ~x_alu_ready).
REQ-027 d_stall = x_stall | load-use | RAW | WAW; f_stall = d_stall.
REQ-028 x_flush = d_stall & ~x_stall (bubble only when Execute advances).
REQ-029 Stall and forward outputs SHALL be purely combinational from inputs and scoreboard state (zero latency); no X-propagation allowed from reset state.
REQ-030 Counters SHALL saturate at all-ones, never wrap.

Reset
REQ-031 While reset is high on an edge: all pending bits, stall_cycles, load_use_cnt SHALL become 0; no scoreboard set occurs that cycle.
REQ-032 Reset mid-operation SHALL drop all in-flight multi-cycle entries; later w_multi writebacks to non-pending registers SHALL be ignored.

Configuration
REQ-033 Macro HAZARD_PERF_CNT_EN defined: stall_cycles increments each cycle d_stall is high; load_use_cnt increments each cycle the load-use term is high.
REQ-034 Macro undefined: counters not instantiated; stall_cycles and load_use_cnt SHALL be constant 0.

Verification
REQ-035 x: lw r5; d: add r6,r5,r1 -> d_stall=1, f_stall=1, x_flush=1 for one cycle; next cycle x_fwd_sel_1=01.
REQ-036 d: mul r7 issued; next d: add r8,r7,r2 -> d_stall held until w_multi writeback of r7, released the following cycle; pending[7]=0.
REQ-037 m_dst=3 and w_dst=3 both writing, x_src_reg_2=3 -> x_fwd_sel_2=01; m_dst=0 with x_src=0 -> 00.
REQ-038 x_alu_ready=0 with x_valid, x_reg_write for 4 cycles -> x_stall=d_stall=1, x_flush=0 for 4 cycles; stall_cycles +4 (macro on) or stays 0 (macro off).
REQ-039 Issue mul r9 and retire r9 same edge -> pending[9]=1; assert reset with pending[9] set -> pending[9]=0, counters 0 next cycle.
